// File: rtl/sde_pkg.sv
// Shared SDE stream-converter types, widths and helpers.
package sde_pkg;

  localparam int SDE_AXIS_CNT_W  = 32;
  localparam int SDE_SLOT_MAX_W  = 6;

  typedef logic [SDE_SLOT_MAX_W-1:0] sde_axis_slot_t;

  function automatic int sde_clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sde_axis_keep_popcnt.sv
// Population count of a tkeep vector, used for byte accounting.
module sde_axis_keep_popcnt
  import sde_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]               keep,
  output logic [$clog2(W+1)-1:0]     cnt
);

  localparam int CW = $clog2(W+1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/sde_c2h_axis_conv.sv
// C2H AXIS ingress: packs CL beats into PCIM words, counts packets.
// Optional byte counter under SDE_C2H_AXIS_BYTE_CNT_EN.
module sde_c2h_axis_conv
  import sde_pkg::*;
#(
  parameter int DESC_TYPE       = 0,
  parameter int PCIM_DATA_WIDTH = 512,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int USER_BIT_WIDTH  = (DESC_TYPE != 0) ? 1 : 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_axis_clr_pkt_cnt,
  output logic [SDE_AXIS_CNT_W-1:0]    axis_cfg_pkt_cnt,
  input  logic                         c2h_axis_valid,
  input  logic [AXIS_DATA_WIDTH-1:0]   c2h_axis_data,
  input  logic [AXIS_DATA_WIDTH/8-1:0] c2h_axis_keep,
  input  logic [USER_BIT_WIDTH-1:0]    c2h_axis_user,
  input  logic                         c2h_axis_last,
  output logic                         c2h_axis_ready,
  output logic                         axis_buf_valid,
  output logic [PCIM_DATA_WIDTH-1:0]   axis_buf_data,
  output logic [PCIM_DATA_WIDTH/8-1:0] axis_buf_keep,
  output logic [USER_BIT_WIDTH-1:0]    axis_buf_user,
  output logic                         axis_buf_last,
  input  logic                         buf_axis_ready,
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
  output logic [63:0]                  axis_cfg_byte_cnt,
`endif
  output logic                         axis_wb_pkt_cnt_req,
  output logic [SDE_AXIS_CNT_W-1:0]    axis_wb_pkt_cnt
);

  localparam int RATIO  = PCIM_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int SLOT_W = sde_clog2_min1(RATIO);
  localparam int IKW    = AXIS_DATA_WIDTH / 8;
  localparam int OKW    = PCIM_DATA_WIDTH / 8;
  localparam sde_axis_slot_t IDX_LAST = sde_axis_slot_t'(RATIO - 1);

  generate
    if ((PCIM_DATA_WIDTH % AXIS_DATA_WIDTH) != 0) begin : g_div_chk
      $fatal(1, "AXIS width must divide PCIM width");
    end
    if ((RATIO & (RATIO - 1)) != 0) begin : g_pow2_chk
      $fatal(1, "width ratio must be a power of 2");
    end
    if (SLOT_W > SDE_SLOT_MAX_W) begin : g_slot_chk
      $fatal(1, "width ratio exceeds slot index range");
    end
  endgenerate

  logic [PCIM_DATA_WIDTH-1:0] data_q, data_d;
  logic [OKW-1:0]             keep_q, keep_d;
  logic [USER_BIT_WIDTH-1:0]  user_q, user_d;
  logic                       last_q, last_d;
  sde_axis_slot_t             idx_q, idx_d;
  logic                       out_valid_q, out_valid_d;
  logic [SDE_AXIS_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic                       wb_req_q, wb_req_d;
  logic                       accept;

  assign c2h_axis_ready = !out_valid_q | buf_axis_ready;
  assign accept         = c2h_axis_valid & c2h_axis_ready;

  always_comb begin
    data_d      = data_q;
    keep_d      = keep_q;
    user_d      = user_q;
    last_d      = last_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && buf_axis_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      // A fresh word must not inherit keep bits from the previous one.
      if (idx_q == '0) begin
        keep_d = '0;
      end
      data_d[int'(idx_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = c2h_axis_data;
      keep_d[int'(idx_q)*IKW +: IKW] = c2h_axis_keep;
      user_d = c2h_axis_user;
      last_d = c2h_axis_last;
      if (c2h_axis_last || (idx_q == IDX_LAST)) begin
        out_valid_d = 1'b1;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + sde_axis_slot_t'(1);
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    wb_req_d  = accept & c2h_axis_last;
    if (cfg_axis_clr_pkt_cnt) begin
      pkt_cnt_d = '0;
    end else if (accept && c2h_axis_last) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      keep_q      <= '0;
      user_q      <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      wb_req_q    <= 1'b0;
    end else begin
      data_q      <= data_d;
      keep_q      <= keep_d;
      user_q      <= user_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      wb_req_q    <= wb_req_d;
    end
  end

  assign axis_buf_valid      = out_valid_q;
  assign axis_buf_data       = data_q;
  assign axis_buf_keep       = keep_q;
  assign axis_buf_user       = user_q;
  assign axis_buf_last       = last_q;
  assign axis_cfg_pkt_cnt    = pkt_cnt_q;
  assign axis_wb_pkt_cnt     = pkt_cnt_q;
  assign axis_wb_pkt_cnt_req = wb_req_q;

`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
  localparam int PCW = $clog2(IKW + 1);

  logic [PCW-1:0] beat_bytes;
  logic [63:0]    byte_cnt_q, byte_cnt_d;

  sde_axis_keep_popcnt #(
    .W (IKW)
  ) u_popcnt (
    .keep (c2h_axis_keep),
    .cnt  (beat_bytes)
  );

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (cfg_axis_clr_pkt_cnt) begin
      byte_cnt_d = '0;
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + 64'(beat_bytes);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign axis_cfg_byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_sde_c2h_axis_conv.sv
// Directed bench for sde_c2h_axis_conv (64->512 packer and 512 passthrough).
module tb_sde_c2h_axis_conv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic         c_valid = 1'b0;
  logic [63:0]  c_data = '0;
  logic [7:0]   c_keep = '0;
  logic [63:0]  c_user = '0;
  logic         c_last = 1'b0;
  logic         c_ready;
  logic         b_valid;
  logic [511:0] b_data;
  logic [63:0]  b_keep;
  logic [63:0]  b_user;
  logic         b_last;
  logic         b_ready = 1'b1;
  logic         wb_req;
  logic [31:0]  wb_cnt;
  logic [31:0]  cfg_cnt;

  logic         d1_valid = 1'b0;
  logic [511:0] d1_data = '0;
  logic [63:0]  d1_keep = '0;
  logic [63:0]  d1_user = '0;
  logic         d1_last = 1'b0;
  logic         d1_ready;
  logic         e1_valid;
  logic [511:0] e1_data;
  logic [63:0]  e1_keep;
  logic [63:0]  e1_user;
  logic         e1_last;
  logic         e1_wb_req;
  logic [31:0]  e1_wb_cnt;
  logic [31:0]  e1_cfg_cnt;
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
  logic [63:0]  byte_cnt;
  logic [63:0]  e1_byte_cnt;
`endif

  sde_c2h_axis_conv dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_axis_clr_pkt_cnt (clr),
    .axis_cfg_pkt_cnt     (cfg_cnt),
    .c2h_axis_valid       (c_valid),
    .c2h_axis_data        (c_data),
    .c2h_axis_keep        (c_keep),
    .c2h_axis_user        (c_user),
    .c2h_axis_last        (c_last),
    .c2h_axis_ready       (c_ready),
    .axis_buf_valid       (b_valid),
    .axis_buf_data        (b_data),
    .axis_buf_keep        (b_keep),
    .axis_buf_user        (b_user),
    .axis_buf_last        (b_last),
    .buf_axis_ready       (b_ready),
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
    .axis_cfg_byte_cnt    (byte_cnt),
`endif
    .axis_wb_pkt_cnt_req  (wb_req),
    .axis_wb_pkt_cnt      (wb_cnt)
  );

  sde_c2h_axis_conv #(
    .AXIS_DATA_WIDTH (512)
  ) dut1 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_axis_clr_pkt_cnt (clr),
    .axis_cfg_pkt_cnt     (e1_cfg_cnt),
    .c2h_axis_valid       (d1_valid),
    .c2h_axis_data        (d1_data),
    .c2h_axis_keep        (d1_keep),
    .c2h_axis_user        (d1_user),
    .c2h_axis_last        (d1_last),
    .c2h_axis_ready       (d1_ready),
    .axis_buf_valid       (e1_valid),
    .axis_buf_data        (e1_data),
    .axis_buf_keep        (e1_keep),
    .axis_buf_user        (e1_user),
    .axis_buf_last        (e1_last),
    .buf_axis_ready       (1'b1),
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
    .axis_cfg_byte_cnt    (e1_byte_cnt),
`endif
    .axis_wb_pkt_cnt_req  (e1_wb_req),
    .axis_wb_pkt_cnt      (e1_wb_cnt)
  );

  function automatic logic [63:0] bd(input int p, input int i);
    return {16'hBEEF, 8'(p), 32'h0, 8'(i)};
  endfunction

  function automatic logic [511:0] word(input int p);
    logic [511:0] w;
    for (int i = 0; i < 8; i++) w[i*64 +: 64] = bd(p, i);
    return w;
  endfunction

  task automatic drive(input logic [63:0] d, input logic l);
    c_valid = 1'b1;
    c_data  = d;
    c_keep  = 8'hFF;
    c_user  = {56'h0, d[7:0]};
    c_last  = l;
  endtask

  task automatic idle();
    c_valid = 1'b0;
    c_last  = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (b_valid !== 1'b0 || cfg_cnt !== 32'h0 || wb_req !== 1'b0 ||
        c_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: valid=%b cnt=%h req=%b rdy=%b want 0 0 0 1",
               b_valid, cfg_cnt, wb_req, c_ready);
    end
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 8; i++) begin
      drive(bd(1, i), i == 7);
      @(negedge clk);
      if (i < 7) begin
        total++;
        if (b_valid !== 1'b0) begin
          bad++;
          $display("FAIL full_early beat %0d: valid=%b want 0", i, b_valid);
        end
      end
    end
    idle();
    total++;
    if (b_valid !== 1'b1 || b_data !== word(1) || b_keep !== '1 ||
        b_last !== 1'b1 || b_user !== 64'h7) begin
      bad++;
      $display("FAIL full_word: v=%b k=%h l=%b u=%h d=%h want 1 all1 1 7 %h",
               b_valid, b_keep, b_last, b_user, b_data, word(1));
    end
    total++;
    if (wb_req !== 1'b1 || cfg_cnt !== 32'd1 || wb_cnt !== 32'd1) begin
      bad++;
      $display("FAIL full_cnt: req=%b cfg=%0d wb=%0d want 1 1 1",
               wb_req, cfg_cnt, wb_cnt);
    end
    @(negedge clk);
    total++;
    if (wb_req !== 1'b0 || b_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_after: req=%b valid=%b want 0 0", wb_req, b_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic bubble = 1'b0;
    logic [511:0] w;
    for (int i = 0; i < 3; i++) begin
      drive(bd(2, i), i == 2);
      @(negedge clk);
    end
    w = word(2);
    total++;
    if (b_valid !== 1'b1 || b_keep !== 64'h0000_0000_00FF_FFFF ||
        b_last !== 1'b1 || b_data[191:0] !== w[191:0]) begin
      bad++;
      $display("FAIL short_word: v=%b k=%h l=%b d=%h want 1 00ffffff 1 %h",
               b_valid, b_keep, b_last, b_data[191:0], w[191:0]);
    end
    for (int i = 0; i < 8; i++) begin
      drive(bd(3, i), i == 7);
      if (c_ready !== 1'b1) bubble = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (b_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_drain: valid=%b want 0", b_valid);
        end
      end
    end
    idle();
    total++;
    if (bubble !== 1'b0) begin
      bad++;
      $display("FAIL b2b_bubble: ready dropped=%b want 0", bubble);
    end
    total++;
    if (b_valid !== 1'b1 || b_data !== word(3) || b_keep !== '1 ||
        b_last !== 1'b1 || cfg_cnt !== 32'd3) begin
      bad++;
      $display("FAIL b2b_word: v=%b k=%h l=%b cnt=%0d want 1 all1 1 3",
               b_valid, b_keep, b_last, cfg_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    b_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(bd(4, i), i == 7);
      @(negedge clk);
    end
    drive(bd(5, 0), 1'b0);
    for (int s = 0; s < 5; s++) begin
      total++;
      if (c_ready !== 1'b0 || b_valid !== 1'b1 || b_data !== word(4) ||
          b_last !== 1'b1) begin
        bad++;
        $display("FAIL stall cyc %0d: rdy=%b v=%b l=%b want 0 1 1 data held",
                 s, c_ready, b_valid, b_last);
      end
      @(negedge clk);
    end
    b_ready = 1'b1;
    @(negedge clk);
    total++;
    if (b_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: valid=%b want 0", b_valid);
    end
    for (int i = 1; i < 8; i++) begin
      drive(bd(5, i), i == 7);
      @(negedge clk);
    end
    idle();
    total++;
    if (b_valid !== 1'b1 || b_data !== word(5) || b_keep !== '1 ||
        cfg_cnt !== 32'd5) begin
      bad++;
      $display("FAIL stall_resume: v=%b k=%h cnt=%0d d=%h want 1 all1 5 %h",
               b_valid, b_keep, cfg_cnt, b_data, word(5));
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_clear();
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    total++;
    if (cfg_cnt !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL preset: cnt=%h want ffffffff", cfg_cnt);
    end
    drive(bd(6, 0), 1'b1);
    @(negedge clk);
    total++;
    if (cfg_cnt !== 32'h0 || wb_cnt !== 32'h0 || wb_req !== 1'b1) begin
      bad++;
      $display("FAIL wrap: cnt=%h wb=%h req=%b want 0 0 1",
               cfg_cnt, wb_cnt, wb_req);
    end
    drive(bd(6, 1), 1'b1);
    @(negedge clk);
    total++;
    if (cfg_cnt !== 32'd1) begin
      bad++;
      $display("FAIL post_wrap: cnt=%0d want 1", cfg_cnt);
    end
    clr = 1'b1;
    drive(bd(6, 2), 1'b1);
    @(negedge clk);
    total++;
    if (cfg_cnt !== 32'h0 || wb_req !== 1'b1) begin
      bad++;
      $display("FAIL clr_wins: cnt=%0d req=%b want 0 1", cfg_cnt, wb_req);
    end
    clr = 1'b0;
    idle();
    @(negedge clk);
    total++;
    if (cfg_cnt !== 32'h0 || wb_req !== 1'b0) begin
      bad++;
      $display("FAIL clr_after: cnt=%0d req=%b want 0 0", cfg_cnt, wb_req);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      drive(bd(7, i), 1'b0);
      @(negedge clk);
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (b_valid !== 1'b0 || cfg_cnt !== 32'h0 || wb_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: v=%b cnt=%0d req=%b want 0 0 0",
               b_valid, cfg_cnt, wb_req);
    end
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
    total++;
    if (byte_cnt !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_bytes: got %0d want 0", byte_cnt);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      drive(bd(8, i), i == 7);
      @(negedge clk);
      if (i < 7) begin
        total++;
        if (b_valid !== 1'b0) begin
          bad++;
          $display("FAIL reset_slot beat %0d: valid=%b want 0", i, b_valid);
        end
      end
    end
    idle();
    total++;
    if (b_valid !== 1'b1 || b_data !== word(8) || b_keep !== '1 ||
        cfg_cnt !== 32'd1) begin
      bad++;
      $display("FAIL reset_word: v=%b k=%h cnt=%0d want 1 all1 1",
               b_valid, b_keep, cfg_cnt);
    end
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
    total++;
    if (byte_cnt !== 64'd64) begin
      bad++;
      $display("FAIL reset_bytes: got %0d want 64", byte_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    for (int p = 0; p < 10; p++) begin
      d1_valid = 1'b1;
      d1_data  = {448'h0, bd(9, p)};
      d1_keep  = 64'hF;
      d1_user  = 64'(p);
      d1_last  = 1'b1;
      @(negedge clk);
      total++;
      if (e1_valid !== 1'b1 || e1_data !== {448'h0, bd(9, p)} ||
          e1_keep !== 64'hF || e1_last !== 1'b1 || e1_user !== 64'(p) ||
          d1_ready !== 1'b1) begin
        bad++;
        $display("FAIL pass pkt %0d: v=%b k=%h l=%b u=%0d r=%b want 1 f 1 %0d 1",
                 p, e1_valid, e1_keep, e1_last, e1_user, d1_ready, p);
      end
    end
    d1_valid = 1'b0;
    d1_last  = 1'b0;
    @(negedge clk);
    total++;
    if (e1_cfg_cnt !== 32'd10 || e1_valid !== 1'b0) begin
      bad++;
      $display("FAIL pass_cnt: cnt=%0d v=%b want 10 0", e1_cfg_cnt, e1_valid);
    end
`ifdef SDE_C2H_AXIS_BYTE_CNT_EN
    total++;
    if (e1_byte_cnt !== 64'd40) begin
      bad++;
      $display("FAIL pass_bytes: got %0d want 40", e1_byte_cnt);
    end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_back_to_back();
    test_backpressure();
    test_wrap_clear();
    test_mid_reset();
    test_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
